bus_port_fifo: RTL

BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

---
 rtl/bus_port_fifo.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bus_port_fifo.sv
// Bus port with independent TX (host -> arbiter) and RX (bus -> host) FWFT queues.
// Optional sticky error flag enabled by defining BUS_PORT_FIFO_ERR_EN.
module bus_port_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  // host side, TX queue
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       tx_full,
  output logic [$clog2(depth+1)-1:0] tx_count,
  // arbiter side
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  // host side, RX queue
  input  logic                       rd_en,
  output logic [pckg_sz-1:0]         rd_data,
  output logic                       rx_empty,
  output logic                       err
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(depth - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(depth);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Pointers wrap explicitly so depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // ------------------------------------------------------------------
  // TX queue
  // ------------------------------------------------------------------
  logic [pckg_sz-1:0] tx_mem [depth];
  logic [PTR_W-1:0]   tx_wr_ptr;
  logic [PTR_W-1:0]   tx_rd_ptr;
  logic [CNT_W-1:0]   tx_cnt;
  logic               tx_is_full;
  logic               tx_is_empty;
  logic               tx_do_wr;
  logic               tx_do_rd;

  assign tx_is_full  = (tx_cnt == CNT_FULL);
  assign tx_is_empty = (tx_cnt == '0);
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign tx_do_wr    = wr_en && (!tx_is_full || pop);
  assign tx_do_rd    = pop && !tx_is_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else begin
      if (tx_do_wr) tx_wr_ptr <= ptr_next(tx_wr_ptr);
      if (tx_do_rd) tx_rd_ptr <= ptr_next(tx_rd_ptr);
      case ({tx_do_wr, tx_do_rd})
        2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
        2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers and count
  // is enough to discard contents, and it keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (!reset && tx_do_wr) tx_mem[tx_wr_ptr] <= wr_data;
  end

  assign tx_full  = tx_is_full;
  assign tx_count = tx_cnt;
  assign pndng    = !tx_is_empty;
  assign D_pop    = tx_mem[tx_rd_ptr];

  // ------------------------------------------------------------------
  // RX queue
  // ------------------------------------------------------------------
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [PTR_W-1:0]   rx_wr_ptr;
  logic [PTR_W-1:0]   rx_rd_ptr;
  logic [CNT_W-1:0]   rx_cnt;
  logic               rx_is_full;
  logic               rx_is_empty;
  logic               rx_do_wr;
  logic               rx_do_rd;

  assign rx_is_full  = (rx_cnt == CNT_FULL);
  assign rx_is_empty = (rx_cnt == '0);
  assign rx_do_wr    = push && (!rx_is_full || rd_en);
  assign rx_do_rd    = rd_en && !rx_is_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_do_wr) rx_wr_ptr <= ptr_next(rx_wr_ptr);
      if (rx_do_rd) rx_rd_ptr <= ptr_next(rx_rd_ptr);
      case ({rx_do_wr, rx_do_rd})
        2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
        2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rx_do_wr) rx_mem[rx_wr_ptr] <= D_push;
  end

  assign rx_empty = rx_is_empty;
  assign rd_data  = rx_mem[rx_rd_ptr];

  // ------------------------------------------------------------------
  // Sticky error flag
  // ------------------------------------------------------------------
`ifdef BUS_PORT_FIFO_ERR_EN
  logic err_q;
  logic err_event;

  // NOTE: combinational logic gets a default first so no path can infer a latch.
  always_comb begin
    err_event = 1'b0;
    if (wr_en && tx_is_full && !pop) err_event = 1'b1;
    if (pop && tx_is_empty)          err_event = 1'b1;
    if (push && rx_is_full && !rd_en) err_event = 1'b1;
    if (rd_en && rx_is_empty)        err_event = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)          err_q <= 1'b0;
    else if (err_event) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
